demux_1to32_reg: RTL and testbench
==================================

# demux_1to32_reg

Registered 1-to-32 word demultiplexer: it is the write-side counterpart of the 32-to-1 read mux. Accepts one 32-bit word per cycle over a valid/ready handshake and stores it into one of 32 held output registers. The destination comes either from an explicit select or from an internal auto-incrementing frame pointer. A per-channel strobe and a frame-done pulse notify downstream logic; the block sits in front of the mux as the register bank it reads from.

## Interface
- WIDTH, 32, data word width
- N, 32, number of output channels (power of two)
- SEL_W, 5, select/pointer width, equal to log2(N)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- x_i  input  WIDTH  input data word
- s_i  input  SEL_W  destination select, used in addressed mode
- valid_i  input  1  word on x_i is valid
- ready_o  output  1  block can accept a word this cycle
- mode_i  input  1  0 = addressed (s_i), 1 = auto-sequence (internal pointer)
- clr_i  input  1  synchronous pointer/frame clear
- y_o  output  N*WIDTH  held channel registers, channel k at bits [k*WIDTH +: WIDTH]
- strobe_o  output  N  one-hot, one-cycle pulse on the channel written
- ptr_o  output  SEL_W  current auto-sequence pointer
- frame_done_o  output  1  one-cycle pulse after the last word of an auto frame

## Operation
- Transfer ("accept") occurs on a rising edge where valid_i && ready_o; nothing changes on non-accepted cycles except strobe_o/frame_done_o returning to 0.
- ready_o is combinational: ready_o = (state != DONE) && !clr_i.
- Addressed accept (mode_i=0): channel s_i <= x_i; strobe_o[s_i] pulses; ptr and state are unchanged, including mid-frame.
- Auto accept (mode_i=1): channel ptr <= x_i; strobe_o[ptr] pulses.
  - If ptr != N-1: ptr <= ptr+1 and state <= FILL.
  - If ptr == N-1: ptr <= 0 (wrap), state <= DONE and frame_done_o pulses.
- State machine:
  - IDLE: ptr = 0, no partial frame. An auto accept moves to FILL, or to DONE when N = 1.
  - FILL: partial frame is in progress.
  - DONE: lasts exactly one cycle with ready_o = 0, then returns unconditionally to IDLE.
- clr_i = 1: on that edge ptr <= 0 and state <= IDLE, no accept can occur (ready_o is low), and y_o is preserved. clr_i in DONE also goes to IDLE.
- Channel registers are only written by accepts. They hold their value indefinitely and are never cleared except by reset.
- Back-to-back accepts to the same channel: the last write wins and the strobe stays high on consecutive cycles.
- Async reset (any time, including mid-frame) clears every output register, y_o, strobe_o, ptr_o and frame_done_o to 0 and sets state to IDLE. ready_o reads 1 as soon as rst_n is high and clr_i is 0.

## Timing
- Write latency is 1 cycle: the word accepted at edge T appears on y_o after edge T, and strobe_o is high for the cycle T..T+1.
- frame_done_o is high in the same cycle as the strobe of the N-th auto word. ready_o is 0 for that one cycle.
- Auto-mode sustained throughput is N words per N+1 cycles. Addressed-mode throughput is 1 word per cycle.
- ptr_o is registered and reflects the pointer after the most recent edge.

## Test plan
- Reset: assert rst_n = 0 mid-stream, asynchronously -> immediately y_o = 0, strobe_o = 0, ptr_o = 0, frame_done_o = 0. After release with clr_i = 0, ready_o = 1.
- Addressed sweep: for i = 0..31 drive s_i = i, x_i = 32'hA0000000+i, valid_i = 1 -> one cycle later channel i = A0000000+i and strobe_o = 1<<i. After the sweep, all 32 channels hold their values.
- Auto frame: mode_i = 1, 32 consecutive words 32'hB0000000+k ->
  - channel k = B0000000+k and ptr_o counts 1..31 then 0;
  - frame_done_o is high in the cycle after the 32nd accept;
  - ready_o is low that cycle, so a word held on valid_i is accepted one cycle later into channel 0.
- Clear mid-frame: after 5 auto words assert clr_i for 1 cycle with valid_i = 1 -> ready_o = 0 that cycle, no write occurs, ptr_o = 0, channels 0..4 are retained, and the next auto word goes to channel 0.
- Mixed mode: during an auto frame with ptr = 7, one addressed write with s_i = 20 -> channel 20 is updated and ptr_o stays 7. The following auto word goes to channel 7.
- No handshake: valid_i = 0 with varying x_i/s_i for 10 cycles -> y_o unchanged and strobe_o = 0 throughout.

Source files
------------

// File: rtl/demux_1to32_reg.sv
// demux_1to32_reg: registered 1-to-N word demultiplexer with addressed and auto-sequence modes
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   x_i          input data word
//   s_i          destination select (addressed mode)
//   valid_i      x_i holds a valid word
//   ready_o      block accepts a word this cycle
//   mode_i       0 = addressed (s_i), 1 = auto-sequence (ptr)
//   clr_i        synchronous pointer/frame clear
//   y_o          held channel registers, channel k at [k*WIDTH +: WIDTH]
//   strobe_o     one-hot pulse on the channel written
//   ptr_o        current auto-sequence pointer
//   frame_done_o pulse after the last word of an auto frame
module demux_1to32_reg #(
  parameter int WIDTH = 32,
  parameter int N     = 32,
  parameter int SEL_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   x_i,
  input  logic [SEL_W-1:0]   s_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               mode_i,
  input  logic               clr_i,
  output logic [N*WIDTH-1:0] y_o,
  output logic [N-1:0]       strobe_o,
  output logic [SEL_W-1:0]   ptr_o,
  output logic               frame_done_o
);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t             state_q;
  logic [N*WIDTH-1:0] y_q;
  logic [N-1:0]       strobe_q;
  logic [SEL_W-1:0]   ptr_q;
  logic               frame_done_q;
  logic               acc;
  logic [SEL_W-1:0]   dest;
  assign ready_o      = (state_q != DONE) && !clr_i;
  assign acc          = valid_i && ready_o;
  assign dest         = mode_i ? ptr_q : s_i;
  assign y_o          = y_q;
  assign strobe_o     = strobe_q;
  assign ptr_o        = ptr_q;
  assign frame_done_o = frame_done_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      y_q          <= '0;
      strobe_q     <= '0;
      ptr_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      strobe_q     <= '0;
      frame_done_q <= 1'b0;
      if (clr_i) begin
        ptr_q   <= '0;
        state_q <= IDLE;
      end else if (state_q == DONE) begin
        state_q <= IDLE;
      end else if (acc) begin
        y_q[dest*WIDTH +: WIDTH] <= x_i;
        strobe_q[dest]           <= 1'b1;
        // addressed writes leave the frame pointer and state untouched, even mid-frame
        if (mode_i) begin
          if (ptr_q == SEL_W'(N-1)) begin
            ptr_q        <= '0;
            state_q      <= DONE;
            frame_done_q <= 1'b1;
          end else begin
            ptr_q   <= ptr_q + 1'b1;
            state_q <= FILL;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_demux_1to32_reg.sv
// tb_demux_1to32_reg: randomized self-checking bench against a frame-count reference model
module tb_demux_1to32_reg;
  localparam int W = 32;
  localparam int N = 32;
  localparam int S = 5;
  logic clk = 0;
  logic rst_n = 0;
  logic [W-1:0] x_i = '0;
  logic [S-1:0] s_i = '0;
  logic valid_i = 0, mode_i = 0, clr_i = 0;
  logic ready_o;
  logic [N*W-1:0] y_o;
  logic [N-1:0] strobe_o;
  logic [S-1:0] ptr_o;
  logic frame_done_o;
  int errors = 0;
  int checks = 0;
  logic [N*W-1:0] m_y = '0;
  logic [N-1:0] m_strobe = '0;
  int m_cnt = 0;
  bit m_done = 0, m_fd = 0;
  bit e_ready, o_ready;

  demux_1to32_reg #(.WIDTH(W), .N(N), .SEL_W(S)) dut (
    .clk(clk), .rst_n(rst_n), .x_i(x_i), .s_i(s_i), .valid_i(valid_i), .ready_o(ready_o),
    .mode_i(mode_i), .clr_i(clr_i), .y_o(y_o), .strobe_o(strobe_o), .ptr_o(ptr_o),
    .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_y = '0; m_strobe = '0; m_cnt = 0; m_done = 0; m_fd = 0;
  endtask

  // drive one cycle starting just after a rising edge and advance the model across that edge
  task automatic cyc(input bit v, input bit m, input int s, input logic [W-1:0] x, input bit c);
    bit acc;
    int d;
    valid_i = v; mode_i = m; s_i = s[S-1:0]; x_i = x; clr_i = c;
    #1;
    o_ready = ready_o;
    e_ready = !m_done && !c;
    acc = v && e_ready;
    @(posedge clk);
    #1;
    m_strobe = '0;
    m_fd = 0;
    if (c) begin
      m_cnt = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (acc) begin
      d = m ? m_cnt : s;
      m_y[d*W +: W] = x;
      m_strobe[d] = 1'b1;
      if (m) begin
        m_cnt++;
        if (m_cnt == N) begin
          m_cnt = 0; m_done = 1; m_fd = 1;
        end
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++; if (y_o !== '0) begin errors++; $display("FAIL reset_y got %h exp 0", y_o); end
    checks++; if (strobe_o !== '0) begin errors++; $display("FAIL reset_strobe got %h exp 0", strobe_o); end
    checks++; if (ptr_o !== '0) begin errors++; $display("FAIL reset_ptr got %0d exp 0", ptr_o); end
    checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL reset_fd got %b exp 0", frame_done_o); end
    #10 rst_n = 1;
    @(posedge clk);
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_o); end
  endtask

  task automatic test_addressed();
    logic [N-1:0] one = 1;
    for (int i = 0; i < N; i++) begin
      cyc(1, 0, i, 32'hA000_0000 + i, 0);
      checks++; if (y_o[i*W +: W] !== 32'hA000_0000 + i) begin errors++; $display("FAIL addr_ch%0d got %h exp %h", i, y_o[i*W +: W], 32'hA000_0000 + i); end
      checks++; if (strobe_o !== one << i) begin errors++; $display("FAIL addr_strobe%0d got %h exp %h", i, strobe_o, one << i); end
      checks++; if (ptr_o !== 5'd0) begin errors++; $display("FAIL addr_ptr%0d got %0d exp 0", i, ptr_o); end
    end
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) begin
      checks++; if (y_o[i*W +: W] !== 32'hA000_0000 + i) begin errors++; $display("FAIL addr_hold_ch%0d got %h exp %h", i, y_o[i*W +: W], 32'hA000_0000 + i); end
    end
    checks++; if (strobe_o !== '0) begin errors++; $display("FAIL addr_strobe_idle got %h exp 0", strobe_o); end
  endtask

  task automatic test_auto_frame();
    logic [N-1:0] one = 1;
    for (int k = 0; k < N; k++) begin
      cyc(1, 1, $urandom_range(0, N-1), 32'hB000_0000 + k, 0);
      checks++; if (y_o[k*W +: W] !== 32'hB000_0000 + k) begin errors++; $display("FAIL auto_ch%0d got %h exp %h", k, y_o[k*W +: W], 32'hB000_0000 + k); end
      checks++; if (ptr_o !== S'((k + 1) % N)) begin errors++; $display("FAIL auto_ptr%0d got %0d exp %0d", k, ptr_o, (k + 1) % N); end
      checks++; if (strobe_o !== one << k) begin errors++; $display("FAIL auto_strobe%0d got %h exp %h", k, strobe_o, one << k); end
      checks++; if (frame_done_o !== (k == N-1)) begin errors++; $display("FAIL auto_fd%0d got %b exp %b", k, frame_done_o, k == N-1); end
    end
    cyc(1, 1, 0, 32'hC000_0000, 0);
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL auto_done_ready got %b exp 0", o_ready); end
    checks++; if (y_o[0 +: W] !== 32'hB000_0000) begin errors++; $display("FAIL auto_done_nowrite got %h exp b0000000", y_o[0 +: W]); end
    checks++; if (strobe_o !== '0 || frame_done_o !== 1'b0) begin errors++; $display("FAIL auto_done_pulses got %h/%b exp 0/0", strobe_o, frame_done_o); end
    cyc(1, 1, 0, 32'hC000_0000, 0);
    checks++; if (y_o[0 +: W] !== 32'hC000_0000) begin errors++; $display("FAIL auto_next_ch0 got %h exp c0000000", y_o[0 +: W]); end
    checks++; if (ptr_o !== 5'd1) begin errors++; $display("FAIL auto_next_ptr got %0d exp 1", ptr_o); end
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic test_clear();
    for (int k = 0; k < 5; k++) cyc(1, 1, 0, 32'hD000_0000 + k, 0);
    cyc(1, 1, 0, 32'hE000_0000, 1);
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL clr_ready got %b exp 0", o_ready); end
    checks++; if (ptr_o !== 5'd0) begin errors++; $display("FAIL clr_ptr got %0d exp 0", ptr_o); end
    checks++; if (strobe_o !== '0) begin errors++; $display("FAIL clr_strobe got %h exp 0", strobe_o); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (y_o[k*W +: W] !== 32'hD000_0000 + k) begin errors++; $display("FAIL clr_keep_ch%0d got %h exp %h", k, y_o[k*W +: W], 32'hD000_0000 + k); end
    end
    cyc(1, 1, 0, 32'hE000_0001, 0);
    checks++; if (y_o[0 +: W] !== 32'hE000_0001) begin errors++; $display("FAIL clr_next_ch0 got %h exp e0000001", y_o[0 +: W]); end
    checks++; if (ptr_o !== 5'd1) begin errors++; $display("FAIL clr_next_ptr got %0d exp 1", ptr_o); end
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic test_mixed();
    for (int k = 0; k < 7; k++) cyc(1, 1, 0, 32'h1000_0000 + k, 0);
    cyc(1, 0, 20, 32'hF000_0020, 0);
    checks++; if (y_o[20*W +: W] !== 32'hF000_0020) begin errors++; $display("FAIL mix_ch20 got %h exp f0000020", y_o[20*W +: W]); end
    checks++; if (ptr_o !== 5'd7) begin errors++; $display("FAIL mix_ptr got %0d exp 7", ptr_o); end
    checks++; if (strobe_o !== 32'h0010_0000) begin errors++; $display("FAIL mix_strobe got %h exp 00100000", strobe_o); end
    cyc(1, 1, 20, 32'hF000_0007, 0);
    checks++; if (y_o[7*W +: W] !== 32'hF000_0007) begin errors++; $display("FAIL mix_ch7 got %h exp f0000007", y_o[7*W +: W]); end
    checks++; if (ptr_o !== 5'd8) begin errors++; $display("FAIL mix_ptr_after got %0d exp 8", ptr_o); end
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic test_no_handshake();
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1'($urandom), $urandom_range(0, N-1), $urandom, 0);
      checks++; if (y_o !== m_y) begin errors++; $display("FAIL nohs_y%0d got %h exp %h", i, y_o, m_y); end
      checks++; if (strobe_o !== '0) begin errors++; $display("FAIL nohs_strobe%0d got %h exp 0", i, strobe_o); end
    end
  endtask

  task automatic test_back_to_back();
    cyc(1, 0, 9, 32'h9999_0001, 0);
    cyc(1, 0, 9, 32'h9999_0002, 0);
    checks++; if (y_o[9*W +: W] !== 32'h9999_0002) begin errors++; $display("FAIL b2b_ch9 got %h exp 99990002", y_o[9*W +: W]); end
    checks++; if (strobe_o !== 32'h0000_0200) begin errors++; $display("FAIL b2b_strobe got %h exp 00000200", strobe_o); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, N-1), $urandom, $urandom_range(0, 19) == 0);
      checks++; if (o_ready !== e_ready) begin errors++; $display("FAIL rnd_ready%0d got %b exp %b", i, o_ready, e_ready); end
      checks++; if (y_o !== m_y) begin errors++; $display("FAIL rnd_y%0d got %h exp %h", i, y_o, m_y); end
      checks++; if (strobe_o !== m_strobe) begin errors++; $display("FAIL rnd_strobe%0d got %h exp %h", i, strobe_o, m_strobe); end
      checks++; if (ptr_o !== S'(m_cnt)) begin errors++; $display("FAIL rnd_ptr%0d got %0d exp %0d", i, ptr_o, m_cnt); end
      checks++; if (frame_done_o !== m_fd) begin errors++; $display("FAIL rnd_fd%0d got %b exp %b", i, frame_done_o, m_fd); end
    end
  endtask

  task automatic test_reset_mid();
    cyc(0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) cyc(1, 1, 0, 32'h7700_0000 + k, 0);
    #2 rst_n = 0;
    #1;
    checks++; if (y_o !== '0) begin errors++; $display("FAIL amid_y got %h exp 0", y_o); end
    checks++; if (strobe_o !== '0) begin errors++; $display("FAIL amid_strobe got %h exp 0", strobe_o); end
    checks++; if (ptr_o !== '0) begin errors++; $display("FAIL amid_ptr got %0d exp 0", ptr_o); end
    checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL amid_fd got %b exp 0", frame_done_o); end
    valid_i = 0; clr_i = 0;
    #10 rst_n = 1;
    model_reset();
    @(posedge clk);
    #1;
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL amid_ready got %b exp 1", ready_o); end
    cyc(1, 1, 0, 32'h7800_0000, 0);
    checks++; if (y_o !== m_y || ptr_o !== 5'd1) begin errors++; $display("FAIL amid_restart got %h ptr %0d exp %h ptr 1", y_o, ptr_o, m_y); end
  endtask

  initial begin
    test_reset();
    test_addressed();
    test_auto_frame();
    test_clear();
    test_mixed();
    test_no_handshake();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
